byte_arbiter: RTL and testbench

- Round-robin arbiter that shares one byte-masked memory port between REQS requesters.
- It is the fan-in counterpart of the byte demultiplexer. It sits between several masters (core ifetch, core LSU, debug/DMA) and a single memory port, or a single demux input.
- Access protocol on both sides: enable/isWrite/writeMask/addr/writeData request, readData response, hold stall.

---
 rtl/byte_arbiter.sv | 99 +++++++++
 tb/tb_byte_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_arbiter.sv
// Round-robin arbiter sharing one byte-masked memory port between REQS requesters.
// Grant is combinational; a stalled access locks its owner until the memory releases hold.
module byte_arbiter #(
   parameter int REQS      = 2,
   parameter int DATA_BYTE = 4,
   parameter int ADDR_SIZE = 32
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [REQS-1:0]               reqEnable_i,
   input  logic [REQS-1:0]               reqIsWrite_i,
   input  logic [REQS*DATA_BYTE-1:0]     reqWriteMask_i,
   input  logic [REQS*ADDR_SIZE-1:0]     reqAddr_i,
   input  logic [REQS*DATA_BYTE*8-1:0]   reqWriteData_i,
   output logic [REQS*DATA_BYTE*8-1:0]   reqReadData_o,
   output logic [REQS-1:0]               reqHold_o,
   output logic                          memEnable_o,
   output logic                          memIsWrite_o,
   output logic [DATA_BYTE-1:0]          memWriteMask_o,
   output logic [ADDR_SIZE-1:0]          memAddr_o,
   output logic [DATA_BYTE*8-1:0]        memWriteData_o,
   input  logic [DATA_BYTE*8-1:0]        memReadData_i,
   input  logic                          memHold_i
);

   localparam int PW = (REQS > 1) ? $clog2(REQS) : 1;
   localparam int DW = DATA_BYTE * 8;

   logic [PW-1:0] rr_ptr;
   logic          lock_valid;
   logic [PW-1:0] lock_owner;
   logic          rd_valid;
   logic [PW-1:0] rd_owner;

   logic [PW-1:0] owner;
   logic [PW-1:0] cand;
   logic          granted;
   logic          done;

   // Search downward so the candidate closest to rr_ptr is the last (winning) assignment.
   always_comb begin
      owner   = rr_ptr;
      granted = 1'b0;
      cand    = '0;
      if (lock_valid) begin
         owner   = lock_owner;
         granted = 1'b1;
      end else begin
         for (int k = REQS - 1; k >= 0; k--) begin
            cand = PW'((int'(rr_ptr) + k) % REQS);
            if (reqEnable_i[cand]) begin
               owner   = cand;
               granted = 1'b1;
            end
         end
      end
   end

   assign done = granted & ~memHold_i;

   always_comb begin
      memEnable_o    = granted & rst_i;
      memIsWrite_o   = reqIsWrite_i[owner];
      memWriteMask_o = reqWriteMask_i[owner*DATA_BYTE +: DATA_BYTE];
      memAddr_o      = reqAddr_i[owner*ADDR_SIZE +: ADDR_SIZE];
      memWriteData_o = reqWriteData_i[owner*DW +: DW];
   end

   // Waiting requesters see their own enable as hold; idle ones see 0.
   always_comb begin
      reqHold_o = reqEnable_i;
      if (granted) reqHold_o[owner] = memHold_i;
      if (!rst_i) reqHold_o = '1;
   end

   always_comb begin
      reqReadData_o = '0;
      if (rst_i && rd_valid) reqReadData_o[rd_owner*DW +: DW] = memReadData_i;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         rr_ptr     <= '0;
         lock_valid <= 1'b0;
         lock_owner <= '0;
         rd_valid   <= 1'b0;
         rd_owner   <= '0;
      end else begin
         lock_valid <= granted & memHold_i;
         lock_owner <= owner;
         if (done) begin
            rr_ptr <= (owner == PW'(REQS - 1)) ? '0 : owner + PW'(1);
         end
         rd_valid <= done & ~reqIsWrite_i[owner];
         rd_owner <= owner;
      end
   end

endmodule

// File: tb/tb_byte_arbiter.sv
// Directed bench for byte_arbiter with four requesters: reset, rotation, stall lock,
// single write, alternating write/read, and reset during a stall.
module tb_byte_arbiter;

   localparam int REQS = 4;
   localparam int DB   = 4;
   localparam int AW   = 32;
   localparam int DW   = DB * 8;

   logic                 clk;
   logic                 rst;
   logic [REQS-1:0]      req_en;
   logic [REQS-1:0]      req_wr;
   logic [REQS*DB-1:0]   req_mask;
   logic [REQS*AW-1:0]   req_addr;
   logic [REQS*DW-1:0]   req_wdata;
   logic [REQS*DW-1:0]   req_rdata;
   logic [REQS-1:0]      req_hold;
   logic                 mem_en;
   logic                 mem_wr;
   logic [DB-1:0]        mem_mask;
   logic [AW-1:0]        mem_addr;
   logic [DW-1:0]        mem_wdata;
   logic [DW-1:0]        mem_rdata;
   logic                 mem_hold;

   int pass_cnt  = 0;
   int total_cnt = 0;

   byte_arbiter #(.REQS(REQS), .DATA_BYTE(DB), .ADDR_SIZE(AW)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .reqEnable_i    (req_en),
      .reqIsWrite_i   (req_wr),
      .reqWriteMask_i (req_mask),
      .reqAddr_i      (req_addr),
      .reqWriteData_i (req_wdata),
      .reqReadData_o  (req_rdata),
      .reqHold_o      (req_hold),
      .memEnable_o    (mem_en),
      .memIsWrite_o   (mem_wr),
      .memWriteMask_o (mem_mask),
      .memAddr_o      (mem_addr),
      .memWriteData_o (mem_wdata),
      .memReadData_i  (mem_rdata),
      .memHold_i      (mem_hold)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      req_en    = '0;
      req_wr    = '0;
      req_mask  = '0;
      req_wdata = '0;
      mem_rdata = '0;
      mem_hold  = 1'b0;
      for (int i = 0; i < REQS; i++) req_addr[i*AW +: AW] = 32'h0000_0100 * (i + 1);
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      clear_inputs();
      req_en = 4'hF;
      mem_rdata = 32'h5555_AAAA;
      rst = 1'b0;
      #2;
      total_cnt++;
      if (mem_en !== 1'b0) $display("FAIL reset_mem_en got=%b exp=0", mem_en); else pass_cnt++;
      total_cnt++;
      if (req_hold !== 4'hF) $display("FAIL reset_hold got=%h exp=f", req_hold); else pass_cnt++;
      tick();
      total_cnt++;
      if (req_rdata !== '0) $display("FAIL reset_rdata got=%h exp=0", req_rdata); else pass_cnt++;
      total_cnt++;
      if (mem_en !== 1'b0) $display("FAIL reset_mem_en_clk got=%b exp=0", mem_en); else pass_cnt++;
      rst = 1'b1;
      #1;
      total_cnt++;
      if (mem_en !== 1'b1 || mem_addr !== 32'h0000_0100)
         $display("FAIL reset_first_grant en=%b addr=%h exp en=1 addr=00000100", mem_en, mem_addr);
      else pass_cnt++;
      total_cnt++;
      if (req_hold !== 4'b1110) $display("FAIL reset_first_hold got=%b exp=1110", req_hold); else pass_cnt++;
   endtask

   task automatic test_round_robin();
      logic [REQS*DW-1:0] exp_rd;
      int                 own;
      do_reset();
      req_en = 4'hF;
      for (int c = 0; c < 9; c++) begin
         mem_rdata = 32'hC0DE_0000 + c;
         #1;
         own = c % REQS;
         total_cnt++;
         if (mem_en !== 1'b1 || mem_addr !== 32'h0000_0100 * (own + 1))
            $display("FAIL rr_grant c=%0d addr=%h exp=%h", c, mem_addr, 32'h0000_0100 * (own + 1));
         else pass_cnt++;
         total_cnt++;
         if (req_hold !== (4'hF & ~(4'b0001 << own)))
            $display("FAIL rr_hold c=%0d got=%b exp=%b", c, req_hold, 4'hF & ~(4'b0001 << own));
         else pass_cnt++;
         exp_rd = '0;
         if (c > 0) exp_rd[((c - 1) % REQS)*DW +: DW] = mem_rdata;
         total_cnt++;
         if (req_rdata !== exp_rd) $display("FAIL rr_rdata c=%0d got=%h exp=%h", c, req_rdata, exp_rd);
         else pass_cnt++;
         tick();
      end
   endtask

   task automatic test_stall_lock();
      do_reset();
      req_addr[1*AW +: AW] = 32'h8000_0010;
      req_addr[0*AW +: AW] = 32'h0000_0A00;
      req_en   = 4'b0010;
      mem_hold = 1'b1;
      for (int c = 0; c < 4; c++) begin
         if (c == 1) req_en = 4'b0011;
         if (c == 3) mem_hold = 1'b0;
         #1;
         total_cnt++;
         if (mem_en !== 1'b1 || mem_addr !== 32'h8000_0010)
            $display("FAIL lock_grant c=%0d addr=%h exp=80000010", c, mem_addr);
         else pass_cnt++;
         total_cnt++;
         if (req_hold !== {2'b00, mem_hold, (c >= 1)})
            $display("FAIL lock_hold c=%0d got=%b exp=%b", c, req_hold, {2'b00, mem_hold, (c >= 1)});
         else pass_cnt++;
         tick();
      end
      req_en    = 4'b0001;
      mem_rdata = 32'h1234_5678;
      #1;
      total_cnt++;
      if (mem_addr !== 32'h0000_0A00) $display("FAIL lock_next_grant addr=%h exp=00000a00", mem_addr);
      else pass_cnt++;
      total_cnt++;
      if (req_rdata !== {64'h0, 32'h1234_5678, 32'h0})
         $display("FAIL lock_rdata got=%h exp=%h", req_rdata, {64'h0, 32'h1234_5678, 32'h0});
      else pass_cnt++;
   endtask

   task automatic test_single_write();
      do_reset();
      req_en                   = 4'b0100;
      req_wr                   = 4'b0100;
      req_mask[2*DB +: DB]     = 4'b0101;
      req_wdata[2*DW +: DW]    = 32'hDEAD_BEEF;
      req_addr[2*AW +: AW]     = 32'h1000_0004;
      mem_rdata                = 32'hFFFF_0000;
      #1;
      total_cnt++;
      if (mem_en !== 1'b1 || mem_wr !== 1'b1) $display("FAIL wr_en_flag en=%b wr=%b exp 1 1", mem_en, mem_wr);
      else pass_cnt++;
      total_cnt++;
      if (mem_mask !== 4'b0101) $display("FAIL wr_mask got=%b exp=0101", mem_mask); else pass_cnt++;
      total_cnt++;
      if (mem_addr !== 32'h1000_0004) $display("FAIL wr_addr got=%h exp=10000004", mem_addr); else pass_cnt++;
      total_cnt++;
      if (mem_wdata !== 32'hDEAD_BEEF) $display("FAIL wr_data got=%h exp=deadbeef", mem_wdata); else pass_cnt++;
      total_cnt++;
      if (req_hold !== 4'b0000) $display("FAIL wr_hold got=%b exp=0000", req_hold); else pass_cnt++;
      tick();
      req_en = '0;
      #1;
      total_cnt++;
      if (req_rdata !== '0) $display("FAIL wr_no_rdata got=%h exp=0", req_rdata); else pass_cnt++;
      total_cnt++;
      if (mem_en !== 1'b0) $display("FAIL wr_idle_en got=%b exp=0", mem_en); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [REQS*DW-1:0] exp_rd;
      int                 own;
      do_reset();
      req_en = 4'b0011;
      req_wr = 4'b0001;
      for (int c = 0; c < 6; c++) begin
         mem_rdata = 32'hB000_0000 + c;
         #1;
         own = c % 2;
         total_cnt++;
         if (mem_addr !== 32'h0000_0100 * (own + 1) || mem_wr !== (own == 0))
            $display("FAIL b2b_grant c=%0d addr=%h wr=%b exp addr=%h", c, mem_addr, mem_wr, 32'h0000_0100 * (own + 1));
         else pass_cnt++;
         exp_rd = '0;
         if (c > 0 && own == 0) exp_rd[1*DW +: DW] = mem_rdata;
         total_cnt++;
         if (req_rdata !== exp_rd) $display("FAIL b2b_rdata c=%0d got=%h exp=%h", c, req_rdata, exp_rd);
         else pass_cnt++;
         tick();
      end
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      req_en   = 4'b1000;
      mem_hold = 1'b1;
      #1;
      total_cnt++;
      if (mem_addr !== 32'h0000_0400) $display("FAIL rst_stall_owner addr=%h exp=00000400", mem_addr);
      else pass_cnt++;
      tick();
      req_en = 4'b1001;
      rst    = 1'b0;
      #1;
      total_cnt++;
      if (mem_en !== 1'b0 || req_hold !== 4'hF)
         $display("FAIL rst_stall_assert en=%b hold=%b exp en=0 hold=1111", mem_en, req_hold);
      else pass_cnt++;
      mem_hold = 1'b0;
      rst      = 1'b1;
      #1;
      total_cnt++;
      if (mem_en !== 1'b1 || mem_addr !== 32'h0000_0100)
         $display("FAIL rst_stall_regrant en=%b addr=%h exp en=1 addr=00000100", mem_en, mem_addr);
      else pass_cnt++;
      total_cnt++;
      if (req_hold !== 4'b1000) $display("FAIL rst_stall_hold got=%b exp=1000", req_hold); else pass_cnt++;
   endtask

   initial begin
      rst = 1'b0;
      clear_inputs();
      @(negedge clk);
      test_reset();
      test_round_robin();
      test_stall_lock();
      test_single_write();
      test_back_to_back();
      test_reset_mid_stall();
      // final report
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
